// File: rtl/mem_arbiter_if.sv
// CPU imem/dmem request ports and the unified memory port of the arbiter.
// slave = arbiter side, master = CPU core and memory side.
interface mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask,
    input  dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask,
    output mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask,
    output dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask,
    input  mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Merges imem/dmem onto one memory port: one pending slot per port,
// one outstanding transaction, round-robin on ties, sticky error flags.
// Ports: clk, rst (sync, active high), bus (mem_arbiter_if.slave),
// err_overrun, err_spurious, err_timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus,
  output logic err_overrun,
  output logic err_spurious,
  output logic err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, nxt;

  logic        i_vld;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic        d_vld;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;

  logic own_d;
  logic last_d;
  logic [CNT_W-1:0] cnt;

  logic i_req, d_req;
  logic pick_d;
  logic tmo_hit, done;

  assign i_req = |bus.imem_rmask;
  assign d_req = |bus.dmem_rmask | |bus.dmem_wmask;

  // On a tie the port that did not win last time gets the grant.
  assign pick_d = d_vld & (~i_vld | ~last_d);

  assign tmo_hit = (state == WAIT) & ~bus.mem_resp
                 & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done = (state == WAIT) & (bus.mem_resp | tmo_hit);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (i_vld | d_vld) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_rmask  = '0;
    bus.mem_wmask  = '0;
    bus.mem_wdata  = '0;
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = '0;
    if ((state == ISSUE) && !rst) begin
      if (own_d) begin
        bus.mem_addr  = d_addr & ~32'h3;
        bus.mem_rmask = d_rmask;
        bus.mem_wmask = d_wmask;
        bus.mem_wdata = d_wdata;
      end else begin
        bus.mem_addr  = i_addr & ~32'h3;
        bus.mem_rmask = i_rmask;
      end
    end
    // A timeout completes the request with zero data.
    if (done && !rst) begin
      if (own_d) begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = bus.mem_resp ? bus.mem_rdata : '0;
      end else begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = bus.mem_resp ? bus.mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i_vld        <= 1'b0;
      i_addr       <= '0;
      i_rmask      <= '0;
      d_vld        <= 1'b0;
      d_addr       <= '0;
      d_rmask      <= '0;
      d_wmask      <= '0;
      d_wdata      <= '0;
      own_d        <= 1'b0;
      last_d       <= 1'b0;
      cnt          <= '0;
      err_overrun  <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state <= nxt;
      if ((state == IDLE) && (i_vld | d_vld)) begin
        own_d  <= pick_d;
        last_d <= pick_d;
      end
      if (state == ISSUE) cnt <= '0;
      else if ((state == WAIT) && !done) cnt <= cnt + 1'b1;

      if (i_req) begin
        if (i_vld) err_overrun <= 1'b1;
        else begin
          i_vld   <= 1'b1;
          i_addr  <= bus.imem_addr;
          i_rmask <= bus.imem_rmask;
        end
      end
      if (done && !own_d) i_vld <= 1'b0;

      if (d_req) begin
        if (d_vld) err_overrun <= 1'b1;
        else begin
          d_vld   <= 1'b1;
          d_addr  <= bus.dmem_addr;
          d_rmask <= bus.dmem_rmask;
          d_wmask <= bus.dmem_wmask;
          d_wdata <= bus.dmem_wdata;
        end
      end
      if (done && own_d) d_vld <= 1'b0;

      if (bus.mem_resp && (state != WAIT)) err_spurious <= 1'b1;
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout.
// Expected values are hand-derived per step.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic err_overrun, err_spurious, err_timeout;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_overrun(err_overrun),
    .err_spurious(err_spurious),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit is_d,
                        input logic [31:0] exp_addr,
                        input logic [31:0] rd);
    int w = 0;
    while (bus.mem_rmask == 0 && bus.mem_wmask == 0 && w < 10) begin
      step();
      w++;
    end
    chk("issue_seen", 32'(w < 10), 32'd1);
    chk("issue_addr", bus.mem_addr, exp_addr);
    step();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = rd;
    #1;
    chk("txn_imem_resp", 32'(bus.imem_resp), 32'(!is_d));
    chk("txn_dmem_resp", 32'(bus.dmem_resp), 32'(is_d));
    chk("txn_rdata", is_d ? bus.dmem_rdata : bus.imem_rdata, rd);
    step();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.imem_addr = '0;
    bus.imem_rmask = '0;
    bus.dmem_addr = '0;
    bus.dmem_rmask = '0;
    bus.dmem_wmask = '0;
    bus.dmem_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_mem_rmask", 32'(bus.mem_rmask), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_resp", 32'({bus.imem_resp, bus.dmem_resp}), 32'h0);
    chk("rst_errs", 32'({err_overrun, err_spurious, err_timeout}), 32'h0);

    // Single fetch, response two cycles after ISSUE.
    step();
    bus.imem_addr = 32'h10;
    bus.imem_rmask = 4'hF;
    #1;
    chk("f_cap_idle", 32'(bus.mem_rmask), 32'h0);
    step();
    bus.imem_rmask = '0;
    chk("f_grant_idle", 32'(bus.mem_rmask), 32'h0);
    step();
    chk("f_issue_rmask", 32'(bus.mem_rmask), 32'hF);
    chk("f_issue_addr", bus.mem_addr, 32'h10);
    chk("f_issue_wmask", 32'(bus.mem_wmask), 32'h0);
    step();
    chk("f_wait1_resp", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("f_imem_resp", 32'(bus.imem_resp), 32'h1);
    chk("f_imem_rdata", bus.imem_rdata, 32'hDEADBEEF);
    chk("f_dmem_resp", 32'(bus.dmem_resp), 32'h0);
    step();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    #1;
    chk("f_resp_pulse", 32'(bus.imem_resp), 32'h0);
    chk("f_rdata_idle", bus.imem_rdata, 32'h0);

    // Fetch and store together: store wins the first tie.
    bus.imem_addr = 32'h40;
    bus.imem_rmask = 4'hF;
    bus.dmem_addr = 32'h100;
    bus.dmem_wmask = 4'h3;
    bus.dmem_wdata = 32'h1234;
    step();
    bus.imem_rmask = '0;
    bus.dmem_wmask = '0;
    step();
    chk("s_issue_wmask", 32'(bus.mem_wmask), 32'h3);
    chk("s_issue_rmask", 32'(bus.mem_rmask), 32'h0);
    chk("s_issue_addr", bus.mem_addr, 32'h100);
    chk("s_issue_wdata", bus.mem_wdata, 32'h1234);
    step();
    bus.mem_resp = 1'b1;
    #1;
    chk("s_dmem_resp", 32'(bus.dmem_resp), 32'h1);
    chk("s_imem_resp", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp = 1'b0;
    chk("s_idle_gap", 32'(bus.mem_rmask), 32'h0);
    step();
    chk("s_fetch_rmask", 32'(bus.mem_rmask), 32'hF);
    chk("s_fetch_addr", bus.mem_addr, 32'h40);
    step();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'hCAFE;
    #1;
    chk("s_fetch_resp", 32'(bus.imem_resp), 32'h1);
    chk("s_fetch_rdata", bus.imem_rdata, 32'hCAFE);
    step();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;

    // Eight tie rounds: grants alternate dmem, imem, dmem, ...
    for (int r = 0; r < 8; r++) begin
      bus.imem_addr = 32'h200 + 32'(r * 4);
      bus.imem_rmask = 4'hF;
      bus.dmem_addr = 32'h300 + 32'(r * 4);
      bus.dmem_rmask = 4'hF;
      step();
      bus.imem_rmask = '0;
      bus.dmem_rmask = '0;
      do_txn(1'b1, 32'h300 + 32'(r * 4), 32'hD000 + 32'(r));
      do_txn(1'b0, 32'h200 + 32'(r * 4), 32'hA000 + 32'(r));
    end

    // Unaligned store address is word aligned on the memory side.
    bus.dmem_addr = 32'h102;
    bus.dmem_wmask = 4'hC;
    bus.dmem_wdata = 32'h55AA0000;
    step();
    bus.dmem_wmask = '0;
    do_txn(1'b1, 32'h100, 32'h0);

    // Second fetch on a full slot: overrun, original completes once.
    chk("o_before", 32'(err_overrun), 32'h0);
    bus.imem_addr = 32'h80;
    bus.imem_rmask = 4'hF;
    step();
    bus.imem_addr = 32'h84;
    step();
    bus.imem_rmask = '0;
    chk("o_flag", 32'(err_overrun), 32'h1);
    do_txn(1'b0, 32'h80, 32'h8080);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_rmask != 0 || bus.imem_resp) seen++;
      step();
    end
    chk("o_single", 32'(seen), 32'h0);

    // Timeout after 8 WAIT cycles, then a late response.
    bus.imem_addr = 32'hA0;
    bus.imem_rmask = 4'hF;
    step();
    bus.imem_rmask = '0;
    step();
    chk("t_issue", bus.mem_addr, 32'hA0);
    step();
    seen = 0;
    for (int k = 1; k < 8; k++) begin
      if (bus.imem_resp) seen++;
      step();
    end
    chk("t_early_resp", 32'(seen), 32'h0);
    chk("t_resp", 32'(bus.imem_resp), 32'h1);
    chk("t_rdata", bus.imem_rdata, 32'h0);
    chk("t_flag_pre", 32'(err_timeout), 32'h0);
    step();
    chk("t_flag", 32'(err_timeout), 32'h1);
    chk("t_idle_resp", 32'(bus.imem_resp), 32'h0);
    chk("t_spur_pre", 32'(err_spurious), 32'h0);
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'h1111;
    #1;
    chk("t_late_nresp", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    chk("t_spurious", 32'(err_spurious), 32'h1);

    // Reset during WAIT of a load abandons it without a response.
    bus.dmem_addr = 32'hB0;
    bus.dmem_rmask = 4'hF;
    step();
    bus.dmem_rmask = '0;
    step();
    step();
    rst = 1'b1;
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'h7777;
    #1;
    chk("r_no_resp", 32'(bus.dmem_resp), 32'h0);
    step();
    rst = 1'b0;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    #1;
    chk("r_errs", 32'({err_overrun, err_spurious, err_timeout}), 32'h0);
    chk("r_mem_rmask", 32'(bus.mem_rmask), 32'h0);
    chk("r_resps", 32'({bus.imem_resp, bus.dmem_resp}), 32'h0);
    chk("r_dmem_rdata", bus.dmem_rdata, 32'h0);
    step();
    step();
    chk("r_slot_clear", 32'(bus.mem_rmask), 32'h0);

    // After reset the first tie goes to dmem again.
    bus.imem_addr = 32'hC0;
    bus.imem_rmask = 4'hF;
    bus.dmem_addr = 32'hC4;
    bus.dmem_rmask = 4'hF;
    step();
    bus.imem_rmask = '0;
    bus.dmem_rmask = '0;
    do_txn(1'b1, 32'hC4, 32'h44);
    do_txn(1'b0, 32'hC0, 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
